// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result and debug-read signals of alu_sequencer.
// master = the sequencer; slave = fetch, ALU and debug side.
interface alu_sequencer_if;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 5;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned INSTR_W = 9;

    logic [INSTR_W-1:0] instr_i;
    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [OP_W-1:0]    alu_opcode_o;
    logic [DATA_W-1:0]  alu_rs_o;
    logic [DATA_W-1:0]  alu_rt_o;
    logic [IMM_W-1:0]   alu_imm_o;
    logic [DATA_W-1:0]  alu_result_i;
    logic               alu_zero_i;
    logic               cb_o;
    logic               retire_o;
    logic               illegal_o;
    logic [IDX_W-1:0]   dbg_addr_i;
    logic [DATA_W-1:0]  dbg_data_o;

    modport master (
        input  instr_i, instr_valid_i, alu_result_i, alu_zero_i, dbg_addr_i,
        output instr_ready_o, alu_opcode_o, alu_rs_o, alu_rt_o, alu_imm_o,
               cb_o, retire_o, illegal_o, dbg_data_o
    );

    modport slave (
        output instr_i, instr_valid_i, alu_result_i, alu_zero_i, dbg_addr_i,
        input  instr_ready_o, alu_opcode_o, alu_rs_o, alu_rt_o, alu_imm_o,
               cb_o, retire_o, illegal_o, dbg_data_o
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: decodes 9-bit instructions, feeds the ALU from an 8x8
// register file and writes back the result or the condition bit. Debug read port: ALU_SEQ_DBG_PORT_EN.
module alu_sequencer #(
    parameter int unsigned ALU_WAIT      = 1,
    parameter logic [7:0]  REG_RESET_VAL = 8'h00
) (
    input  logic            clk_i,
    input  logic            reset_i,
    alu_sequencer_if.master bus
);
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned IMM_W    = 5;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned INSTR_W  = 9;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned WAIT_N   = (ALU_WAIT < 1) ? 1 : ALU_WAIT;
    localparam int unsigned CNT_W    = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;
    localparam logic [OP_W-1:0]  OP_ILLEGAL = 4'b1111;
    localparam logic [IDX_W-1:0] RT_IDX     = 3'd7;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    typedef enum logic [1:0] {WB_NONE, WB_REG, WB_CB, WB_ILL} wb_kind_t;

    state_t             state_q, state_d;
    wb_kind_t           kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [IDX_W-1:0]   dest_q, dest_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  rs_q, rs_d;
    logic [DATA_W-1:0]  rt_q, rt_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               cb_q, cb_d;
    logic               retire_q, retire_d;
    logic               illegal_q, illegal_d;
    logic               reg_we;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [OP_W-1:0]    dec_op;
    logic [IDX_W-1:0]   dec_idx;

    assign dec_op  = instr_q[INSTR_W-1 -: OP_W];
    assign dec_idx = instr_q[IMM_W-1 -: IDX_W];

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        dest_d    = dest_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        cb_d      = cb_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        reg_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid_i) begin
                    instr_d = bus.instr_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                rs_d   = regs[dec_idx];
                rt_d   = regs[RT_IDX];
                imm_d  = instr_q[IMM_W-1:0];
                op_d   = dec_op;
                dest_d = dec_idx;
                kind_d = WB_REG;
                case (dec_op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: kind_d = WB_REG;
                    4'b1000:          dest_d = '0;
                    4'b0101, 4'b0111: kind_d = WB_CB;
                    default: begin
                        kind_d = WB_ILL;
                        op_d   = OP_ILLEGAL;
                    end
                endcase
                cnt_d   = '0;
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == CNT_W'(WAIT_N - 1)) begin
                    state_d   = WB;
                    retire_d  = 1'b1;
                    illegal_d = (kind_q == WB_ILL);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WB: begin
                // The ALU is only sampled here; the write lands on the edge leaving WB
                state_d = IDLE;
                if (kind_q == WB_REG) reg_we = 1'b1;
                if (kind_q == WB_CB)  cb_d   = bus.alu_zero_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            kind_q    <= WB_NONE;
            cnt_q     <= '0;
            instr_q   <= '0;
            dest_q    <= '0;
            op_q      <= OP_ILLEGAL;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            cb_q      <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            dest_q    <= dest_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            cb_q      <= cb_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET_VAL;
        end else if (reg_we) begin
            regs[dest_q] <= bus.alu_result_i;
        end
    end

    assign bus.instr_ready_o = (state_q == IDLE) & ~reset_i;
    assign bus.alu_opcode_o  = op_q;
    assign bus.alu_rs_o      = rs_q;
    assign bus.alu_rt_o      = rt_q;
    assign bus.alu_imm_o     = imm_q;
    assign bus.cb_o          = cb_q;
    assign bus.retire_o      = retire_q;
    assign bus.illegal_o     = illegal_q;

`ifdef ALU_SEQ_DBG_PORT_EN
    assign bus.dbg_data_o = regs[bus.dbg_addr_i];
`else
    assign bus.dbg_data_o = '0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table vectors, randomized instructions against a
// register-file/ALU reference model, held-valid throughput and mid-operation reset.
module tb_alu_sequencer;
    localparam int unsigned W0   = 1;
    localparam int unsigned W1   = 3;
    localparam logic [7:0]  RST1 = 8'hA5;

    logic clk = 1'b0;
    logic rst0, rst1;

    alu_sequencer_if b0 ();
    alu_sequencer_if b1 ();

    alu_sequencer #(.ALU_WAIT(W0), .REG_RESET_VAL(8'h00)) u0 (.clk_i(clk), .reset_i(rst0), .bus(b0));
    alu_sequencer #(.ALU_WAIT(W1), .REG_RESET_VAL(RST1))  u1 (.clk_i(clk), .reset_i(rst1), .bus(b1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       ovr_en;
    logic [7:0] ovr_val;
    logic [7:0] mregs [8];
    logic       mcb;

    // Behavioural ALU: {zero, result}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [4:0] imm);
        logic [7:0] r;
        logic       z;
        r = 8'h00;
        z = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a + b;
            4'd2: r = a << b[2:0];
            4'd3: r = a >> b[2:0];
            4'd4: r = a - b;
            4'd5: z = ($signed(a) < $signed(b));
            4'd6: r = a[7] ? 8'(8'h00 - a) : a;
            4'd7: z = (a == b);
            4'd8: r = {3'b000, imm};
            default: r = 8'h00;
        endcase
        if (op != 4'd5 && op != 4'd7) z = (r == 8'h00);
        return {z, r};
    endfunction

    logic [8:0] alu0_r, alu1_r;
    assign alu0_r = alu_f(b0.alu_opcode_o, b0.alu_rs_o, b0.alu_rt_o, b0.alu_imm_o);
    assign alu1_r = alu_f(b1.alu_opcode_o, b1.alu_rs_o, b1.alu_rt_o, b1.alu_imm_o);
    assign b0.alu_result_i = ovr_en ? ovr_val : alu0_r[7:0];
    assign b0.alu_zero_i   = alu0_r[8];
    assign b1.alu_result_i = alu1_r[7:0];
    assign b1.alu_zero_i   = alu1_r[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full instruction on u0 with explicit expectations; also advances the model
    task automatic do_instr(input string tag, input logic [8:0] ins, input logic oe, input logic [7:0] ov,
                            input logic [7:0] e_rs, input logic [7:0] e_rt, input logic e_cb);
        logic [3:0]  opc, e_op;
        logic        e_ill;
        logic [7:0]  rv, iv, dv;
        logic [24:0] ex_out, wb_out, e_out;
        logic [8:0]  res;
        int          g;
        opc   = ins[8:5];
        e_ill = (opc >= 4'd9);
        e_op  = e_ill ? 4'hF : opc;
        e_out = {e_op, e_rs, e_rt, ins[4:0]};
        g = 0;
        while (!b0.instr_ready_o && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s ready_wait: got ready=0 for 20 cycles, expected ready=1", tag);
        end
        b0.instr_i       = ins;
        b0.instr_valid_i = 1'b1;
        ovr_en  = oe;
        ovr_val = ov;
        rv = '0; iv = '0; dv = '0; ex_out = '0; wb_out = '0;
        @(posedge clk);
        for (int k = 1; k <= 3 + W0; k++) begin
            @(negedge clk);
            if (k == 1) b0.instr_valid_i = 1'b0;
            rv[k] = b0.retire_o;
            iv[k] = b0.illegal_o;
            dv[k] = b0.instr_ready_o;
            if (k == 2)      ex_out = {b0.alu_opcode_o, b0.alu_rs_o, b0.alu_rt_o, b0.alu_imm_o};
            if (k == 2 + W0) wb_out = {b0.alu_opcode_o, b0.alu_rs_o, b0.alu_rt_o, b0.alu_imm_o};
        end
        chk({tag, " exec_operands"}, 32'(ex_out), 32'(e_out));
        chk({tag, " wb_operands"},   32'(wb_out), 32'(e_out));
        chk({tag, " retire_seq"},    32'(rv), 32'(8'(1 << (2 + W0))));
        chk({tag, " illegal_seq"},   32'(iv), e_ill ? 32'(8'(1 << (2 + W0))) : 32'h0);
        chk({tag, " ready_seq"},     32'(dv), 32'(8'(1 << (3 + W0))));
        chk({tag, " cb"},            32'(b0.cb_o), 32'(e_cb));
        ovr_en = 1'b0;
        res = alu_f(e_op, mregs[ins[4:2]], mregs[7], ins[4:0]);
        case (opc)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6: mregs[ins[4:2]] = oe ? ov : res[7:0];
            4'd8:       mregs[0] = oe ? ov : res[7:0];
            4'd5, 4'd7: mcb = res[8];
            default: ;
        endcase
    endtask

    task automatic do_model(input string tag, input logic [8:0] ins, input logic oe, input logic [7:0] ov);
        logic [8:0] res;
        logic       e_cb;
        res  = alu_f(ins[8:5], mregs[ins[4:2]], mregs[7], ins[4:0]);
        e_cb = (ins[8:5] == 4'd5 || ins[8:5] == 4'd7) ? res[8] : mcb;
        do_instr(tag, ins, oe, ov, mregs[ins[4:2]], mregs[7], e_cb);
    endtask

    task automatic chk_dbg(input string tag);
        for (int i = 0; i < 8; i++) begin
            b0.dbg_addr_i = 3'(i);
            @(negedge clk);
`ifdef ALU_SEQ_DBG_PORT_EN
            chk($sformatf("%s dbg_r%0d", tag, i), 32'(b0.dbg_data_o), 32'(mregs[i]));
`else
            chk($sformatf("%s dbg_r%0d", tag, i), 32'(b0.dbg_data_o), 32'h0);
`endif
        end
    endtask

    typedef struct packed {
        logic [8:0] ins;
        logic       oe;
        logic [7:0] ov;
        logic [7:0] rs;
        logic [7:0] rt;
        logic       cb;
    } vec_t;

    function automatic vec_t mkv(input logic [8:0] ins, input logic oe, input logic [7:0] ov,
                                 input logic [7:0] rs, input logic [7:0] rt, input logic cb);
        vec_t v;
        v.ins = ins; v.oe = oe; v.ov = ov; v.rs = rs; v.rt = rt; v.cb = cb;
        return v;
    endfunction

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [2:0] r);
        return {op, r, 2'b00};
    endfunction

    vec_t       tbl[$];
    logic [8:0] prog [3];
    logic [7:0] gaps [2];
    logic [7:0] rs_seen [3];
    logic [7:0] rv;
    int         idx, nacc, nret, low_run;
    logic       hs_pend;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1000000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        ovr_en = 1'b0; ovr_val = 8'h00;
        b0.instr_i = '0; b0.instr_valid_i = 1'b0; b0.dbg_addr_i = '0;
        b1.instr_i = '0; b1.instr_valid_i = 1'b0; b1.dbg_addr_i = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mcb = 1'b0;

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_u0_outs", 32'({b0.alu_opcode_o, b0.alu_rs_o, b0.alu_rt_o, b0.alu_imm_o, b0.cb_o,
                                b0.retire_o, b0.illegal_o, b0.instr_ready_o}), 32'({4'hF, 25'h0}));
        chk("rst_u1_outs", 32'({b1.alu_opcode_o, b1.alu_rs_o, b1.alu_rt_o, b1.alu_imm_o, b1.cb_o,
                                b1.retire_o, b1.illegal_o, b1.instr_ready_o}), 32'({4'hF, 25'h0}));
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("rst_release_ready", 32'({b0.instr_ready_o, b1.instr_ready_o}), 32'h3);

        // Directed vectors, ALU_WAIT=1
        tbl.push_back(mkv({4'h8, 5'd20},          1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd3),        1'b1, 8'h0F, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd7),        1'b1, 8'h01, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mkv(enc(4'h1, 3'd3),        1'b0, 8'h00, 8'h0F, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h4, 3'd3),        1'b0, 8'h00, 8'h10, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd3),        1'b1, 8'hF0, 8'h0F, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h6, 3'd3),        1'b0, 8'h00, 8'hF0, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h3, 3'd3),        1'b0, 8'h00, 8'h10, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd2),        1'b1, 8'h03, 8'h00, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd7),        1'b1, 8'h05, 8'h01, 8'h01, 1'b0));
        tbl.push_back(mkv(enc(4'h5, 3'd2),        1'b0, 8'h00, 8'h03, 8'h05, 1'b1));
        tbl.push_back(mkv(enc(4'h7, 3'd2),        1'b0, 8'h00, 8'h03, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h0, 3'd2),        1'b1, 8'h05, 8'h03, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h7, 3'd2),        1'b0, 8'h00, 8'h05, 8'h05, 1'b1));
        tbl.push_back(mkv({4'hA, 3'd2, 2'b11},    1'b1, 8'hEE, 8'h05, 8'h05, 1'b1));
        tbl.push_back(mkv(enc(4'h5, 3'd2),        1'b0, 8'h00, 8'h05, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h2, 3'd0),        1'b0, 8'h00, 8'h14, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h5, 3'd0),        1'b0, 8'h00, 8'h80, 8'h05, 1'b1));
        tbl.push_back(mkv(enc(4'h5, 3'd3),        1'b0, 8'h00, 8'h08, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h1, 3'd7),        1'b0, 8'h00, 8'h05, 8'h05, 1'b0));
        tbl.push_back(mkv(enc(4'h7, 3'd7),        1'b0, 8'h00, 8'h0A, 8'h0A, 1'b1));
        tbl.push_back(mkv(enc(4'hF, 3'd1),        1'b0, 8'h00, 8'h00, 8'h0A, 1'b1));
        foreach (tbl[i])
            do_instr($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].oe, tbl[i].ov, tbl[i].rs, tbl[i].rt, tbl[i].cb);
        chk_dbg("after_tbl");

        // Randomized instructions against the model
        for (int n = 0; n < 150; n++) begin
            logic [8:0] ins;
            ins = {4'($urandom_range(0, 15)), 5'($urandom)};
            do_model($sformatf("rnd%0d", n), ins, ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        for (int i = 0; i < 8; i++) do_model($sformatf("probe%0d", i), enc(4'h5, 3'(i)), 1'b0, 8'h00);
        chk_dbg("after_rnd");

        // Reset during EXEC of an add to r4
        do_model("pre_r4", enc(4'h0, 3'd4), 1'b1, 8'h77);
        do_model("pre_cb", enc(4'h7, 3'd7), 1'b0, 8'h00);
        b0.instr_i = enc(4'h1, 3'd4);
        b0.instr_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b0.instr_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_exec_op", 32'(b0.alu_opcode_o), 32'h1);
        rst0 = 1'b1;
        #1;
        chk("midrst_outs", 32'({b0.alu_opcode_o, b0.alu_rs_o, b0.alu_rt_o, b0.alu_imm_o, b0.cb_o,
                                b0.retire_o, b0.illegal_o, b0.instr_ready_o}), 32'({4'hF, 25'h0}));
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(b0.instr_ready_o), 32'h1);
        rv = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rv[k] = b0.retire_o;
        end
        chk("midrst_no_retire", 32'(rv), 32'h0);
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mcb = 1'b0;
        do_model("midrst_probe_r4", enc(4'h5, 3'd4), 1'b0, 8'h00);
        chk_dbg("after_midrst");

        // ALU_WAIT=3 with instr_valid held high across three instructions
        prog[0] = enc(4'h1, 3'd1);
        prog[1] = enc(4'h5, 3'd1);
        prog[2] = enc(4'h7, 3'd7);
        gaps[0] = 8'hFF; gaps[1] = 8'hFF;
        rs_seen[0] = 8'hFF; rs_seen[1] = 8'hFF; rs_seen[2] = 8'hFF;
        idx = 0; nacc = 0; nret = 0; low_run = 0; hs_pend = 1'b0;
        @(negedge clk);
        b1.instr_i = prog[0];
        b1.instr_valid_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (hs_pend) begin
                idx++;
                hs_pend = 1'b0;
                if (idx < 3) b1.instr_i = prog[idx];
                else         b1.instr_valid_i = 1'b0;
            end
            if (b1.retire_o) begin
                if (nret < 3) rs_seen[nret] = b1.alu_rs_o;
                nret++;
            end
            if (b1.instr_valid_i) begin
                if (b1.instr_ready_o) begin
                    if (nacc > 0 && nacc < 3) gaps[nacc-1] = 8'(low_run);
                    nacc++;
                    low_run = 0;
                    hs_pend = 1'b1;
                end else begin
                    low_run++;
                end
            end
            @(negedge clk);
        end
        chk("hold_accepts",   32'(nacc), 32'd3);
        chk("hold_retires",   32'(nret), 32'd3);
        chk("hold_gap0",      32'(gaps[0]), 32'd5);
        chk("hold_gap1",      32'(gaps[1]), 32'd5);
        chk("hold_rs0_reset", 32'(rs_seen[0]), 32'(RST1));
        chk("hold_rs1_wb",    32'(rs_seen[1]), 32'(8'(RST1 + RST1)));
        chk("hold_rs2_r7",    32'(rs_seen[2]), 32'(RST1));
        chk("hold_cb",        32'(b1.cb_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
